// File: rtl/arb8_32bit_ctrl_if.sv
// Bundle for the 8-source arbiter: request/data from producers, registered word to the consumer.
// Latency: n/a (signal bundle only).
// Backpressure: out_ready from the consumer stalls the output register and suppresses ack.
interface arb8_32bit_ctrl_if;
   logic [7:0]  req;
   logic [31:0] src_in0;
   logic [31:0] src_in1;
   logic [31:0] src_in2;
   logic [31:0] src_in3;
   logic [31:0] src_in4;
   logic [31:0] src_in5;
   logic [31:0] src_in6;
   logic [31:0] src_in7;
   logic [7:0]  ack;
   logic [2:0]  sel;
   logic        out_valid;
   logic [31:0] out_data;
   logic [2:0]  out_src;
   logic        out_ready;

   // Arbiter side
   modport slave (
      input  req, src_in0, src_in1, src_in2, src_in3,
             src_in4, src_in5, src_in6, src_in7, out_ready,
      output ack, sel, out_valid, out_data, out_src
   );

   // Producer/consumer side
   modport master (
      output req, src_in0, src_in1, src_in2, src_in3,
             src_in4, src_in5, src_in6, src_in7, out_ready,
      input  ack, sel, out_valid, out_data, out_src
   );
endinterface

// File: rtl/arb8_32bit_ctrl.sv
// Round-robin (or fixed-priority) arbiter over eight 32-bit sources with a one-entry output register.
// Latency: 1 cycle from req to out_valid; 1 word/cycle sustained while out_ready is high.
// Backpressure: when full and out_ready is low, all registers hold and ack stays 0.

// Plain 8:1 32-bit word mux, steered by the arbiter's select.
module mux8_1_32bit (
   input  logic [2:0]  sel,
   input  logic [31:0] in0,
   input  logic [31:0] in1,
   input  logic [31:0] in2,
   input  logic [31:0] in3,
   input  logic [31:0] in4,
   input  logic [31:0] in5,
   input  logic [31:0] in6,
   input  logic [31:0] in7,
   output logic [31:0] out
);
   // Select one of the eight words
   always_comb begin
      out = in0;
      case (sel)
         3'd0: out = in0;
         3'd1: out = in1;
         3'd2: out = in2;
         3'd3: out = in3;
         3'd4: out = in4;
         3'd5: out = in5;
         3'd6: out = in6;
         3'd7: out = in7;
         default: out = in0;
      endcase
   end
endmodule

module arb8_32bit_ctrl #(
   parameter bit FIXED_PRIO = 1'b0
) (
   input logic              clk,
   input logic              rst_n,
   arb8_32bit_ctrl_if.slave bus
);
   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

   state_t      state_q, state_d;
   logic [2:0]  ptr_q, ptr_d;
   logic [31:0] data_q, data_d;
   logic [2:0]  src_q, src_d;

   logic [2:0]  win;
   logic [2:0]  idx;
   logic [2:0]  sel_w;
   logic        any_req;
   logic        load;
   logic [31:0] mux_out;

   // Winner scan: walk from the farthest position back to ptr so the nearest set bit is kept
   always_comb begin
      win = ptr_q;
      idx = 3'd0;
      for (int k = 7; k >= 0; k--) begin
         idx = ptr_q + 3'(k);
         if (bus.req[idx]) win = idx;
      end
   end

   // Select, load and ack; reset forces select to 0 and blocks any grant
   always_comb begin
      any_req = |bus.req;
      sel_w   = rst_n ? win : 3'd0;
      load    = rst_n & any_req & ((state_q == EMPTY) | bus.out_ready);
   end

   assign bus.sel = sel_w;
   assign bus.ack = load ? (8'd1 << sel_w) : 8'd0;

   mux8_1_32bit u_mux (
      .sel (sel_w),
      .in0 (bus.src_in0),
      .in1 (bus.src_in1),
      .in2 (bus.src_in2),
      .in3 (bus.src_in3),
      .in4 (bus.src_in4),
      .in5 (bus.src_in5),
      .in6 (bus.src_in6),
      .in7 (bus.src_in7),
      .out (mux_out)
   );

   // Next state: load captures the winner and advances ptr; an unrefilled accept drains to EMPTY
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      data_d  = data_q;
      src_d   = src_q;
      if (load) begin
         state_d = FULL;
         data_d  = mux_out;
         src_d   = sel_w;
         ptr_d   = FIXED_PRIO ? 3'd0 : (sel_w + 3'd1);
      end else if ((state_q == FULL) && bus.out_ready) begin
         state_d = EMPTY;
      end
   end

   // State and output registers; reset discards any held word
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EMPTY;
         ptr_q   <= 3'd0;
         data_q  <= 32'd0;
         src_q   <= 3'd0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         data_q  <= data_d;
         src_q   <= src_d;
      end
   end

   assign bus.out_valid = (state_q == FULL);
   assign bus.out_data  = data_q;
   assign bus.out_src   = src_q;
endmodule

// File: doc/arb8_32bit_ctrl.md
# arb8_32bit_ctrl

Eight-requester round-robin arbiter and output stage for the 32-bit 8:1 datapath mux. It arbitrates among eight 32-bit sources and drives the 3-bit select of an internal `mux8_1_32bit` instance. The winning word is captured into a one-entry output register with a valid/ready handshake. The block sits between the eight producers (register-file read ports, ALU, immediates, PC, load data and similar) and the single consumer that shares the 32-bit bus.

## Interface
- `FIXED_PRIO`, default 0
  - 0: round-robin arbitration.
  - 1: fixed priority; the lowest index always wins and the pointer stays at 0.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `req` in 8: request bit per source; `req[i]` belongs to `src_in{i}`.
- `src_in0` … `src_in7` in 32 each: source data. Each must be held stable while its `req` is high.
- `ack` out 8: one-hot, combinational. It is high in the cycle in which that source's data is captured.
- `sel` out 3: index of the current winner. It drives the internal mux select combinationally.
- `out_valid` out 1: the output register holds a word.
- `out_data` out 32: registered word.
- `out_src` out 3: registered index of the source that produced `out_data`.
- `out_ready` in 1: consumer accepts `out_data` this cycle.

## Operation
- **Registers and states**
  - Registers: `ptr[2:0]` (highest-priority index), `out_valid`, `out_data`, `out_src`.
  - States: EMPTY (`out_valid=0`) and FULL (`out_valid=1`).
- **Load condition:** `load = |req & (~out_valid | out_ready)`.
- **Winner selection** (combinational, every cycle):
  - Scan `req` starting at `ptr`, upward with wrap 7→0.
  - The winner is the first set bit. `sel` = winner index.
  - When `req==0`, `sel` = `ptr`.
- **`ack`:** `ack = load ? onehot(sel) : 8'b0`.
  - At most one bit is set.
  - The source may deassert `req` or change its data on the cycle after `ack`.
- **On `load` (clock edge):**
  - `out_data` ← mux output (`src_in[sel]`).
  - `out_src` ← `sel`; `out_valid` ← 1.
  - `ptr` ← `sel+1` mod 8, so 7 wraps to 0. When `FIXED_PRIO=1`, `ptr` stays 0.
- **Transitions:**
  - EMPTY & `req==0`: stay EMPTY; all registers hold.
  - EMPTY & `|req`: load → FULL.
  - FULL & `~out_ready`: hold all registers, `ack=0` (back-pressure).
  - FULL & `out_ready` & `|req`: load in the same cycle (back-to-back) → FULL.
  - FULL & `out_ready` & `req==0`: `out_valid` ← 0 → EMPTY. `out_data` and `out_src` hold their stale values.
- **Edge cases:**
  - `out_ready` while EMPTY is ignored.
  - A requester whose `req` drops before it is acked is skipped, and no data is captured from it.
  - All eight requesting with `out_ready` held high: grants rotate `ptr`, `ptr+1`, …, and each source is served exactly once per 8 transfers.

## Timing
- **Reset (`rst_n` low, asynchronous):**
  - `ptr=0`, `out_valid=0`, `out_data=0`, `out_src=0`.
  - `ack` is forced to 0 and `sel` reads 0 for as long as `rst_n` is low.
- **Reset mid-transfer:** the held word is discarded, with no `ack` and no output.
- **Release:** the first load can occur on the first rising edge after `rst_n` rises.
- **Latency:** `req` to `out_valid` is 1 cycle from EMPTY.
- **Throughput:** 1 word per cycle while `out_ready` stays high.
- **Combinational paths:**
  - `ack` depends on `req`, `ptr`, `out_valid` and `out_ready`.
  - `sel` depends on `req` and `ptr`.
- **Registered outputs:** `out_data` and `out_src` change only on a load edge.
- **Handshake rule:** a word is transferred downstream on any edge where `out_valid & out_ready`.

## Test plan
- **Reset:**
  - Stimulus: drive `rst_n=0` mid-FULL with `req=8'hFF`.
  - Required: `out_valid`, `out_data` and `ack` go to 0 immediately. After release, the first grant is to source 0.
- **Single request:**
  - Stimulus: `req=8'h20`, `src_in5=32'hDEADBEEF`, `out_ready=1`.
  - Required: `ack=8'h20` in cycle 0. In cycle 1, `out_valid=1`, `out_data=32'hDEADBEEF`, `out_src=5`. Next `ptr=6`.
- **Round-robin fairness and wrap:**
  - Stimulus: `req=8'hFF` held, `out_ready=1`, `src_inN=N`.
  - Required: `out_data` sequence 0,1,…,7,0,1 with no idle cycles.
- **Back-pressure:**
  - Stimulus: FULL holding source 2 with `out_ready=0` for 3 cycles while `req=8'h09`.
  - Required: `ack=0` and `out_data` stable. When `out_ready` rises, source 3 is acked (`ptr=3`) and loaded the same cycle.
- **Drain to EMPTY:**
  - Stimulus: FULL, `out_ready=1`, `req=0`.
  - Required: `out_valid` falls next cycle. `out_data` keeps its last value.
- **Fixed priority (`FIXED_PRIO=1`):**
  - Stimulus: `req=8'h82` held.
  - Required: source 1 wins on every transfer and source 7 is never acked.
